ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/ifetch_buf.sv | 89 ++++++++
 rtl/ifetch_unit.sv | 72 +++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch unit.
//   fetch_entry_t : one buffered fetch, {pc, instr}
//   occ_e         : prefetch buffer occupancy (EMPTY / ONE / FULL)
//   PC_INC        : byte distance between consecutive instruction words
package ifetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry prefetch buffer holding {pc, instr} pairs.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i        : write wdata_i at the tail (ignored when FULL without pop)
//   pop_i         : consume the head (ignored when EMPTY)
//   flush_i       : discard all entries; overrides push and pop
//   wdata_i       : entry to write
//   occ_o         : current occupancy
//   valid_o       : head holds a valid entry
//   head_o        : head entry, all-zero when EMPTY
module ifetch_buf
  import ifetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output occ_e         occ_o,
  output logic         valid_o,
  output fetch_entry_t head_o
);

  // ent0 is always the head; ent1 is only meaningful when FULL.
  occ_e         occ_q, occ_d;
  fetch_entry_t ent0_q, ent0_d;
  fetch_entry_t ent1_q, ent1_d;
  logic         do_pop;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    do_pop = pop_i && (occ_q != EMPTY);

    if (flush_i) begin
      occ_d = EMPTY;
    end else begin
      case (occ_q)
        EMPTY: begin
          if (push_i) begin
            ent0_d = wdata_i;
            occ_d  = ONE;
          end
        end
        ONE: begin
          if (push_i && do_pop) begin
            ent0_d = wdata_i;
          end else if (push_i) begin
            ent1_d = wdata_i;
            occ_d  = FULL;
          end else if (do_pop) begin
            occ_d = EMPTY;
          end
        end
        FULL: begin
          // A push without a pop is dropped here: the buffer never overflows.
          if (do_pop) begin
            ent0_d = ent1_q;
            if (push_i) ent1_d = wdata_i;
            else        occ_d  = ONE;
          end
        end
        default: occ_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    if (!rst_ni) begin
      occ_q  <= EMPTY;
      // NOTE: storage entries are cleared on reset so stale data can never reach the outputs.
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign occ_o   = occ_q;
  assign valid_o = (occ_q != EMPTY);
  assign head_o  = valid_o ? ent0_q : '0;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: fetch PC, combinational instruction memory
// interface, redirect handling and a 2-entry prefetch buffer.
// Ports:
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   imem_addr_o     : fetch byte address (= fetch PC)
//   imem_instr_i    : instruction word for imem_addr_o, same cycle
//   redirect_i      : flush buffer and refetch from redirect_pc_i
//   redirect_pc_i   : redirect target (low two bits ignored)
//   instr_valid_o   : buffer head valid
//   instr_o, pc_o   : head instruction and its byte address (0 when empty)
//   instr_ready_i   : decode consumes the head this cycle
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i
);

  logic [31:0]  fpc_q, fpc_d;
  logic         push, pop;
  occ_e         occ;
  fetch_entry_t head;
  fetch_entry_t wdata;

  assign imem_addr_o = fpc_q;

  // A pop coincident with a redirect still counts as consumed; the buffer
  // simply flushes and nothing else is done for it.
  assign pop   = instr_valid_o && instr_ready_i;
  assign push  = !redirect_i && ((occ != FULL) || pop);
  assign wdata = '{pc: fpc_q, instr: imem_instr_i};

  always_comb begin
    fpc_d = fpc_q;
    if (redirect_i) begin
      fpc_d = redirect_pc_i & 32'hFFFF_FFFC;
    end else if (push) begin
      fpc_d = fpc_q + PC_INC;  // wraps modulo 2^32
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) fpc_q <= RESET_PC;
    else         fpc_q <= fpc_d;
  end

  ifetch_buf u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .wdata_i (wdata),
    .occ_o   (occ),
    .valid_o (instr_valid_o),
    .head_o  (head)
  );

  assign instr_o = head.instr;
  assign pc_o    = head.pc;

endmodule
